// File: rtl/calc_pkg.sv
// Shared definitions for the calc_top calculator: FSM state codes, operation
// select values and the 7-segment pattern table ({g,f,e,d,c,b,a}, active-high).
package calc_pkg;

   typedef enum logic [3:0] {
      ST_LOAD_A = 4'd0,
      ST_LOAD_B = 4'd1,
      ST_EXEC   = 4'd2,
      ST_WRITE  = 4'd3,
      ST_DONE   = 4'd4
   } state_t;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

   // Entry [n] is the glyph for hex digit n; element 15 is listed first.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/hex7seg.sv
// Hex digit to 7-segment decoder. Define SEG_ACTIVE_LOW_EN to invert the
// outputs for common-anode displays.
module hex7seg
   import calc_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg
);

`ifdef SEG_ACTIVE_LOW_EN
   assign seg = ~SEG_TABLE[value];
`else
   assign seg = SEG_TABLE[value];
`endif

endmodule

// File: rtl/calc_top.sv
// Two-operand 4-bit add/subtract calculator driven by a fixed 5-cycle
// sequencer. Display polarity follows SEG_ACTIVE_LOW_EN (see hex7seg).
module calc_top
   import calc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] Dados,
   input  logic       Instrucao,
   output logic [6:0] Disp_RegA,
   output logic [6:0] Disp_RegB,
   output logic [6:0] Disp_Saida,
   output logic [3:0] state,
   output logic [4:0] saida_regC,
   output logic       fim
);

   state_t     state_q, state_d;
   logic [3:0] reg_a, reg_b;
   logic [4:0] alu_r, reg_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LOAD_A;
         reg_a   <= '0;
         reg_b   <= '0;
         alu_r   <= '0;
         reg_c   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_LOAD_A: reg_a <= Dados;
            ST_LOAD_B: reg_b <= Dados;
            // 5-bit difference wraps mod 32, so bit 4 doubles as the borrow
            ST_EXEC:   alu_r <= (op_t'(Instrucao) == OP_SUB) ?
                                ({1'b0, reg_a} - {1'b0, reg_b}) :
                                ({1'b0, reg_a} + {1'b0, reg_b});
            ST_WRITE:  reg_c <= alu_r;
            default:   ;
         endcase
      end
   end

   always_comb begin
      state_d = ST_LOAD_A;
      case (state_q)
         ST_LOAD_A: state_d = ST_LOAD_B;
         ST_LOAD_B: state_d = ST_EXEC;
         ST_EXEC:   state_d = ST_WRITE;
         ST_WRITE:  state_d = ST_DONE;
         default:   state_d = ST_LOAD_A;
      endcase
   end

   assign state      = state_q;
   assign saida_regC = reg_c;
   assign fim        = (state_q == ST_DONE);

   hex7seg u_disp_a (.value(reg_a),      .seg(Disp_RegA));
   hex7seg u_disp_b (.value(reg_b),      .seg(Disp_RegB));
   hex7seg u_disp_c (.value(reg_c[3:0]), .seg(Disp_Saida));

endmodule

// File: tb/tb_calc_top.sv
// Self-checking bench for calc_top: directed and exhaustive passes compared
// against an arithmetic reference model and an independent segment table.
module tb_calc_top;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] Dados;
   logic       Instrucao;
   logic [6:0] Disp_RegA, Disp_RegB, Disp_Saida;
   logic [3:0] state;
   logic [4:0] saida_regC;
   logic       fim;

   int n_checks = 0;
   int n_pass   = 0;
   logic [4:0] model_c;

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   calc_top dut (
      .clk(clk), .rst(rst), .Dados(Dados), .Instrucao(Instrucao),
      .Disp_RegA(Disp_RegA), .Disp_RegB(Disp_RegB), .Disp_Saida(Disp_Saida),
      .state(state), .saida_regC(saida_regC), .fim(fim)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_exp(input logic [3:0] v);
`ifdef SEG_ACTIVE_LOW_EN
      return ~seg_tab[v];
`else
      return seg_tab[v];
`endif
   endfunction

   function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic op);
      int r;
      r = op ? (int'(a) - int'(b)) : (int'(a) + int'(b));
      return 5'((r + 32) % 32);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      Dados = 4'($urandom);
      Instrucao = 1'($urandom);
      tick();
      tick();
      n_checks++; if (state !== 4'd0) $display("FAIL reset_state got %0d want 0", state); else n_pass++;
      n_checks++; if (saida_regC !== 5'd0) $display("FAIL reset_regC got %h want 00", saida_regC); else n_pass++;
      n_checks++; if (fim !== 1'b0) $display("FAIL reset_fim got %b want 0", fim); else n_pass++;
      n_checks++; if (Disp_RegA !== seg_exp(4'd0)) $display("FAIL reset_dispA got %h want %h", Disp_RegA, seg_exp(4'd0)); else n_pass++;
      n_checks++; if (Disp_RegB !== seg_exp(4'd0)) $display("FAIL reset_dispB got %h want %h", Disp_RegB, seg_exp(4'd0)); else n_pass++;
      n_checks++; if (Disp_Saida !== seg_exp(4'd0)) $display("FAIL reset_dispC got %h want %h", Disp_Saida, seg_exp(4'd0)); else n_pass++;
      rst = 1'b0;
      model_c = '0;
   endtask

   // One full 5-cycle pass; Instrucao is scrambled outside EXEC on purpose.
   task automatic do_pass(input logic [3:0] a, input logic [3:0] b, input logic op);
      logic [4:0] want;
      want = model(a, b, op);
      n_checks++; if (state !== 4'd0) $display("FAIL pass_start_state got %0d want 0", state); else n_pass++;
      Dados = a; Instrucao = 1'($urandom);
      tick();
      n_checks++; if (state !== 4'd1) $display("FAIL state_loadb got %0d want 1", state); else n_pass++;
      n_checks++; if (Disp_RegA !== seg_exp(a)) $display("FAIL dispA a=%h got %h want %h", a, Disp_RegA, seg_exp(a)); else n_pass++;
      n_checks++; if (fim !== 1'b0) $display("FAIL fim_loadb got %b want 0", fim); else n_pass++;
      Dados = b; Instrucao = 1'($urandom);
      tick();
      n_checks++; if (state !== 4'd2) $display("FAIL state_exec got %0d want 2", state); else n_pass++;
      n_checks++; if (Disp_RegB !== seg_exp(b)) $display("FAIL dispB b=%h got %h want %h", b, Disp_RegB, seg_exp(b)); else n_pass++;
      n_checks++; if (saida_regC !== model_c) $display("FAIL regC_hold_exec got %h want %h", saida_regC, model_c); else n_pass++;
      Dados = 4'($urandom); Instrucao = op;
      tick();
      n_checks++; if (state !== 4'd3) $display("FAIL state_write got %0d want 3", state); else n_pass++;
      n_checks++; if (saida_regC !== model_c) $display("FAIL regC_hold_write got %h want %h", saida_regC, model_c); else n_pass++;
      n_checks++; if (fim !== 1'b0) $display("FAIL fim_write got %b want 0", fim); else n_pass++;
      Dados = 4'($urandom); Instrucao = ~op;
      tick();
      model_c = want;
      n_checks++; if (state !== 4'd4) $display("FAIL state_done got %0d want 4", state); else n_pass++;
      n_checks++; if (saida_regC !== want) $display("FAIL result a=%h b=%h op=%b got %h want %h", a, b, op, saida_regC, want); else n_pass++;
      n_checks++; if (fim !== 1'b1) $display("FAIL fim_done got %b want 1", fim); else n_pass++;
      n_checks++; if (Disp_Saida !== seg_exp(want[3:0])) $display("FAIL dispC got %h want %h", Disp_Saida, seg_exp(want[3:0])); else n_pass++;
      Dados = 4'($urandom); Instrucao = 1'($urandom);
      tick();
      n_checks++; if (state !== 4'd0) $display("FAIL state_wrap got %0d want 0", state); else n_pass++;
      n_checks++; if (fim !== 1'b0) $display("FAIL fim_after got %b want 0", fim); else n_pass++;
      n_checks++; if (saida_regC !== want) $display("FAIL regC_hold_after got %h want %h", saida_regC, want); else n_pass++;
      n_checks++; if (Disp_RegA !== seg_exp(a)) $display("FAIL dispA_hold got %h want %h", Disp_RegA, seg_exp(a)); else n_pass++;
   endtask

   task automatic test_add();
      do_pass(4'hE, 4'hF, 1'b0);
      n_checks++; if (saida_regC !== 5'h1D) $display("FAIL add_EF got %h want 1d", saida_regC); else n_pass++;
   endtask

   task automatic test_sub();
      do_pass(4'hE, 4'hF, 1'b1);
      n_checks++; if (saida_regC !== 5'h1F) $display("FAIL sub_EF got %h want 1f", saida_regC); else n_pass++;
      do_pass(4'hF, 4'h0, 1'b1);
      n_checks++; if (saida_regC !== 5'h0F) $display("FAIL sub_F0 got %h want 0f", saida_regC); else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_pass(4'($urandom), 4'($urandom), 1'($urandom));
      do_pass(4'h0, 4'h0, 1'b0);
      for (int unsigned i = 0; i < 6; i++)
         do_pass(4'($urandom), 4'($urandom), 1'($urandom));
   endtask

   task automatic test_reset_mid_op();
      Dados = 4'($urandom);
      tick();
      Dados = 4'($urandom);
      tick();
      n_checks++; if (state !== 4'd2) $display("FAIL midrst_pre_state got %0d want 2", state); else n_pass++;
      rst = 1'b1; Instrucao = 1'($urandom);
      tick();
      n_checks++; if (state !== 4'd0) $display("FAIL midrst_state got %0d want 0", state); else n_pass++;
      n_checks++; if (saida_regC !== 5'd0) $display("FAIL midrst_regC got %h want 00", saida_regC); else n_pass++;
      n_checks++; if (Disp_RegA !== seg_exp(4'd0)) $display("FAIL midrst_dispA got %h want %h", Disp_RegA, seg_exp(4'd0)); else n_pass++;
      rst = 1'b0;
      model_c = '0;
      do_pass(4'($urandom), 4'($urandom), 1'($urandom));
   endtask

   task automatic test_exhaustive();
      for (int unsigned op = 0; op < 2; op++)
         for (int unsigned a = 0; a < 16; a++)
            for (int unsigned b = 0; b < 16; b++)
               do_pass(4'(a), 4'(b), 1'(op));
   endtask

   initial begin
      rst = 1'b1;
      Dados = '0;
      Instrucao = 1'b0;
      model_c = '0;
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_reset_mid_op();
      test_exhaustive();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/calc_top.md
Name: calc_top

Overview:
- Small two-operand 4-bit calculator with a fixed 5-cycle sequencer.
- Each pass loads operand A, then operand B, from a shared 4-bit data bus, computes A+B or A−B as selected by `Instrucao`, and latches a 5-bit result.
- Drives three 7-segment displays (A, B, result low nibble) and signals completion with `fim`.
- Top-level board block; inputs come from switches, outputs go to HEX displays and LEDs.

Parameters:
- None. Widths are fixed: operands 4 bits, result 5 bits, state 4 bits.

Ports:
- `clk` input 1: system clock, rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `Dados` input 4: shared operand bus, sampled in LOAD_A and LOAD_B.
- `Instrucao` input 1: operation select; 0 = add, 1 = subtract. Sampled in EXEC.
- `Disp_RegA` output 7: 7-seg pattern of regA.
- `Disp_RegB` output 7: 7-seg pattern of regB.
- `Disp_Saida` output 7: 7-seg pattern of regC[3:0].
- `state` output 4: current FSM state code.
- `saida_regC` output 5: result register.
- `fim` output 1: done flag.

Behaviour:
- Registers: regA[3:0], regB[3:0], alu_r[4:0] (internal), regC[4:0], state[3:0].
- Reset (rst=1 at a rising edge) sets:
  - state=LOAD_A(0); regA=regB=alu_r=regC=0; fim=0.
  - Displays then show "0" on all three digits.
- Reset has priority over everything, including mid-sequence; the next pass restarts at LOAD_A.
- FSM: every state lasts exactly one cycle, unconditional loop of 5 cycles.
  - LOAD_A (0): regA<=Dados; next LOAD_B.
  - LOAD_B (1): regB<=Dados; next EXEC.
  - EXEC (2): alu_r <= Instrucao ? ({1'b0,regA} − {1'b0,regB}) mod 32 : {1'b0,regA} + {1'b0,regB}; next WRITE.
  - WRITE (3): regC<=alu_r; next DONE.
  - DONE (4): fim=1; next LOAD_A.
  - Codes 5–15 are illegal; next state is LOAD_A, no register updates.
- Arithmetic:
  - Add: result 0..30; bit4 is the carry.
  - Subtract: 5-bit two's complement; bit4=1 means A<B (borrow/negative).
  - Example: 14−15 = 5'h1F.
- `fim` is high only while state==DONE; it is decoded from the registered state, so it is glitch-free.
- Timing from reset release:
  - A is sampled at edge 1 and B at edge 2.
  - regC is valid after edge 4, together with `fim`=1 in that cycle.
  - The next A is sampled at edge 6.
- `saida_regC`, regA and regB hold their values between updates.
- Displays are combinational decodes of the registers; no extra latency.
- Segment encoding is {g,f,e,d,c,b,a}, active-high by default:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- `Disp_Saida` shows regC[3:0] only; bit4 is visible solely on `saida_regC`.
- `Instrucao` changes outside EXEC have no effect on the current pass.

Optional Feature:
- Macro: `SEG_ACTIVE_LOW_EN`.
- Defined: all three display outputs are bitwise inverted (common-anode boards), including the reset value.
  - Example: "0" becomes 7'h40.
- Undefined: active-high patterns as listed above.
- FSM, registers and `fim` are identical either way.

Decomposition:
- Package calc_pkg holds:
  - State codes: ST_LOAD_A=0, ST_LOAD_B=1, ST_EXEC=2, ST_WRITE=3, ST_DONE=4.
  - OP_ADD=0, OP_SUB=1.
  - The 16-entry segment pattern constant table.
- One sub-module, hex7seg: 4-bit value in, 7-bit pattern out, honouring `SEG_ACTIVE_LOW_EN`. Instantiated three times.
- FSM, ALU and registers stay in calc_top.

Test Plan:
- Reset: hold rst=1 for 2 cycles.
  - Expect state=0, saida_regC=0, fim=0, all displays 7'h3F.
- Add A=E, B=F, Instrucao=0: drive Dados=E for 1 cycle, then F.
  - Expect state sequence 0,1,2,3,4.
  - After edge 4: saida_regC=5'h1D, fim=1 for exactly 1 cycle.
  - Disp_Saida=5E ("d"), Disp_RegA=79, Disp_RegB=71.
- Subtract A=E, B=F, Instrucao=1:
  - Expect saida_regC=5'h1F, Disp_Saida=71.
  - Subtract A=F, B=0: expect 5'h0F.
- Back-to-back passes with no reset: second pass A=0, B=0, add.
  - Expect saida_regC=0, fim pulsing every 5th cycle.
  - regC holds the previous value until WRITE.
- Reset mid-op: assert rst in EXEC.
  - Expect next state=0 and regC=0; the following pass computes correctly.
- Exhaustive: all 256 A/B pairs for both ops (5 cycles each).
  - Compare against the add/sub model and the segment table.
